// File: rtl/blastn_pkg.sv
// Shared definitions for the seed-alignment scheduler: FSM states,
// default hit threshold and nucleotide / padding codes.
package blastn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_FLUSH  = 3'd5
   } state_e;

   localparam logic [1:0] THRESH_DEF = 2'b10;

   localparam logic [1:0] NT_A = 2'b00;
   localparam logic [1:0] NT_C = 2'b01;
   localparam logic [1:0] NT_G = 2'b10;
   localparam logic [1:0] NT_T = 2'b11;

   localparam logic [1:0] PAD_CHAR = NT_A;

endpackage

// File: rtl/hit_fifo2.sv
// Two-entry hit FIFO with valid/ready pop side; a push while full is
// accepted only when a pop happens in the same cycle.
module hit_fifo2 #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_valid,
   input  logic [W-1:0] push_data,
   output logic         hit_valid,
   input  logic         hit_ready,
   output logic [W-1:0] hit_pos,
   output logic [1:0]   count
);

   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop, push;

   assign pop  = (cnt_q != 2'd0) && hit_ready;
   assign push = push_valid && ((cnt_q != 2'd2) || pop);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = push_data;
            else               tail_d = push_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // Occupancy unchanged: the new entry lands behind whatever remains.
            if (cnt_q == 2'd1) begin
               head_d = push_data;
            end else begin
               head_d = tail_q;
               tail_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign hit_valid = (cnt_q != 2'd0);
   assign hit_pos   = head_q;
   assign count     = cnt_q;

endmodule

// File: rtl/align_scheduler.sv
// Control scheduler for a systolic seed-alignment array: loads the query,
// streams database chars, drains with padding and queues scored hits.
// Optional HIT_COUNT_EN adds a saturating hit_count output.
module align_scheduler
   import blastn_pkg::*;
#(
   parameter int unsigned QLEN   = 8,
   parameter int unsigned POS_W  = 16,
   parameter logic [1:0]  THRESH = THRESH_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    q_valid,
   output logic                    q_ready,
   input  logic [1:0]              q_data,
   input  logic                    d_valid,
   output logic                    d_ready,
   input  logic [1:0]              d_data,
   input  logic                    d_last,
   output logic                    arr_clear,
   output logic                    arr_qload,
   output logic [$clog2(QLEN)-1:0] arr_qidx,
   output logic [1:0]              arr_qchar,
   output logic                    arr_shift,
   output logic [1:0]              arr_dchar,
   output logic                    arr_pad,
   input  logic [1:0]              arr_score,
   output logic                    hit_valid,
   input  logic                    hit_ready,
   output logic [POS_W-1:0]        hit_pos,
   output logic                    busy,
   output logic                    done
`ifdef HIT_COUNT_EN
   ,
   output logic [POS_W-1:0]        hit_count
`endif
);

   localparam int unsigned        QIDX_W    = $clog2(QLEN);
   localparam logic [QIDX_W-1:0]  QIDX_LAST = QIDX_W'(QLEN - 1);
   localparam logic [QIDX_W-1:0]  QIDX_ONE  = QIDX_W'(1);

   state_e             state_q, state_d;
   logic [QIDX_W-1:0]  qidx_q, qidx_d;
   logic [QIDX_W-1:0]  drain_q, drain_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [POS_W-1:0]   infl_pos_q, infl_pos_d;
   logic               infl_q, infl_d;
   logic               shift;
   logic               shift_ok;
   logic               push_valid;
   logic [1:0]         fifo_cnt;

   // Back-pressure counts the shift whose score is still in flight.
   assign shift_ok   = ({1'b0, fifo_cnt} + {2'b00, infl_q}) < 3'd2;
   assign push_valid = infl_q && (arr_score >= THRESH);

   always_comb begin
      state_d    = state_q;
      qidx_d     = qidx_q;
      drain_d    = drain_q;
      pos_d      = pos_q;
      infl_pos_d = infl_pos_q;
      shift      = 1'b0;
      q_ready    = 1'b0;
      d_ready    = 1'b0;
      arr_clear  = 1'b0;
      arr_qload  = 1'b0;
      arr_qidx   = '0;
      arr_qchar  = '0;
      arr_dchar  = '0;
      arr_pad    = 1'b0;
      done       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            arr_clear = 1'b1;
            qidx_d    = '0;
            pos_d     = '0;
            state_d   = ST_LOAD;
         end
         ST_LOAD: begin
            q_ready = 1'b1;
            if (q_valid) begin
               arr_qload = 1'b1;
               arr_qidx  = qidx_q;
               arr_qchar = q_data;
               if (qidx_q == QIDX_LAST) begin
                  qidx_d  = '0;
                  state_d = ST_STREAM;
               end else begin
                  qidx_d = qidx_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            d_ready   = shift_ok;
            shift     = d_valid && shift_ok;
            arr_dchar = d_data;
            if (shift && d_last) begin
               drain_d = QIDX_LAST;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            shift     = shift_ok;
            arr_dchar = PAD_CHAR;
            arr_pad   = 1'b1;
            if (shift) begin
               drain_d = drain_q - 1'b1;
               if (drain_q == QIDX_ONE) state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (!infl_q && (fifo_cnt == 2'd0)) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (shift) begin
         infl_pos_d = pos_q;
         pos_d      = pos_q + 1'b1;
      end
      infl_d = shift;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         qidx_q     <= '0;
         drain_q    <= '0;
         pos_q      <= '0;
         infl_pos_q <= '0;
         infl_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         qidx_q     <= qidx_d;
         drain_q    <= drain_d;
         pos_q      <= pos_d;
         infl_pos_q <= infl_pos_d;
         infl_q     <= infl_d;
      end
   end

   assign arr_shift = shift;
   assign busy      = (state_q != ST_IDLE);

   hit_fifo2 #(
      .W (POS_W)
   ) u_hit_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (push_valid),
      .push_data  (infl_pos_q),
      .hit_valid  (hit_valid),
      .hit_ready  (hit_ready),
      .hit_pos    (hit_pos),
      .count      (fifo_cnt)
   );

`ifdef HIT_COUNT_EN
   logic [POS_W-1:0] hit_count_q, hit_count_d;

   always_comb begin
      hit_count_d = hit_count_q;
      if (state_q == ST_CLEAR)
         hit_count_d = '0;
      else if (push_valid && (hit_count_q != '1))
         hit_count_d = hit_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hit_count_q <= '0;
      else        hit_count_q <= hit_count_d;
   end

   assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_align_scheduler.sv
// Directed bench for align_scheduler (QLEN=4) plus a POS_W=4 twin sharing
// the same stimulus, and a direct check of the two-entry hit FIFO.
module tb_align_scheduler;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        q_valid;
   logic [1:0]  q_data;
   logic        d_valid;
   logic [1:0]  d_data;
   logic        d_last;
   logic [1:0]  arr_score;
   logic        hit_ready;

   logic        q_ready, d_ready, arr_clear, arr_qload, arr_shift, arr_pad;
   logic [1:0]  arr_qidx, arr_qchar, arr_dchar;
   logic        hit_valid, busy, done;
   logic [15:0] hit_pos;

   logic        q_ready_w, d_ready_w, arr_clear_w, arr_qload_w, arr_shift_w, arr_pad_w;
   logic [1:0]  arr_qidx_w, arr_qchar_w, arr_dchar_w;
   logic        hit_valid_w, busy_w, done_w;
   logic [3:0]  hit_pos_w;

`ifdef HIT_COUNT_EN
   logic [15:0] hit_count;
   logic [3:0]  hit_count_w;
`endif

   logic        f_pv, f_rdy, f_valid;
   logic [15:0] f_pd, f_pos;
   logic [1:0]  f_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   int          score_mode;
   int          sh_cnt;
   int          done_cnt;
   int          pad_cnt;
   int          dhs_cnt;
   logic [15:0] hits[$];
   logic [3:0]  hits_w[$];

   logic [31:0] outs_vec, outs_w_vec;
   assign outs_vec   = {1'b0, busy, done, q_ready, d_ready, arr_clear, arr_qload,
                        arr_qidx, arr_qchar, arr_shift, arr_dchar, arr_pad,
                        hit_valid, hit_pos};
   assign outs_w_vec = {13'd0, busy_w, done_w, q_ready_w, d_ready_w, arr_clear_w,
                        arr_qload_w, arr_qidx_w, arr_qchar_w, arr_shift_w,
                        arr_dchar_w, arr_pad_w, hit_valid_w, hit_pos_w};

   align_scheduler #(.QLEN(4), .POS_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data), .d_last(d_last),
      .arr_clear(arr_clear), .arr_qload(arr_qload), .arr_qidx(arr_qidx),
      .arr_qchar(arr_qchar), .arr_shift(arr_shift), .arr_dchar(arr_dchar),
      .arr_pad(arr_pad), .arr_score(arr_score),
      .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_pos(hit_pos),
      .busy(busy), .done(done)
`ifdef HIT_COUNT_EN
      , .hit_count(hit_count)
`endif
   );

   align_scheduler #(.QLEN(4), .POS_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start),
      .q_valid(q_valid), .q_ready(q_ready_w), .q_data(q_data),
      .d_valid(d_valid), .d_ready(d_ready_w), .d_data(d_data), .d_last(d_last),
      .arr_clear(arr_clear_w), .arr_qload(arr_qload_w), .arr_qidx(arr_qidx_w),
      .arr_qchar(arr_qchar_w), .arr_shift(arr_shift_w), .arr_dchar(arr_dchar_w),
      .arr_pad(arr_pad_w), .arr_score(arr_score),
      .hit_valid(hit_valid_w), .hit_ready(hit_ready), .hit_pos(hit_pos_w),
      .busy(busy_w), .done(done_w)
`ifdef HIT_COUNT_EN
      , .hit_count(hit_count_w)
`endif
   );

   hit_fifo2 #(.W(16)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push_valid(f_pv), .push_data(f_pd),
      .hit_valid(f_valid), .hit_ready(f_rdy), .hit_pos(f_pos), .count(f_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the PE array: score appears the cycle after each shift.
   // Mode 0: score 2 only for the shift with index 2, else 1. Mode 1: always 3.
   always @(posedge clk) begin
      if (arr_clear)      sh_cnt <= 0;
      else if (arr_shift) sh_cnt <= sh_cnt + 1;
      if (arr_shift)
         arr_score <= (score_mode == 1) ? 2'd3 : ((sh_cnt == 2) ? 2'd2 : 2'd1);
      else
         arr_score <= 2'd0;
   end

   always @(posedge clk) begin
      if (hit_valid && hit_ready)     hits.push_back(hit_pos);
      if (hit_valid_w && hit_ready)   hits_w.push_back(hit_pos_w);
      if (done)                       done_cnt <= done_cnt + 1;
      if (arr_shift && arr_pad)       pad_cnt  <= pad_cnt + 1;
      if (d_valid && d_ready)         dhs_cnt  <= dhs_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_and_load(input string tag);
      logic [1:0] qchars [4];
      qchars[0] = 2'b00; qchars[1] = 2'b01; qchars[2] = 2'b10; qchars[3] = 2'b11;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_clear"}, {30'd0, arr_clear, busy}, 32'h3);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         q_valid = 1'b1;
         q_data  = qchars[i];
         #1;
         check({tag, "_qload"}, {27'd0, arr_qload, arr_qidx, arr_qchar},
               {27'd0, 1'b1, i[1:0], qchars[i]});
         @(negedge clk);
      end
      q_valid = 1'b0;
      #1 check({tag, "_stream_rdy"}, {31'd0, d_ready}, 32'd1);
   endtask

   task automatic stream(input int n);
      logic acc;
      for (int k = 0; k < n; k++) begin
         d_valid = 1'b1;
         d_data  = k[1:0];
         d_last  = (k == n - 1);
         acc     = 1'b0;
         for (int t = 0; t < 200 && !acc; t++) begin
            #1;
            if (d_ready) acc = 1'b1;
            @(negedge clk);
         end
         if (!acc) check("d_timeout", 32'd0, 32'd1);
      end
      d_valid = 1'b0;
      d_last  = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      for (int t = 0; t < 400 && done_cnt == d0; t++) @(negedge clk);
      check("done_seen", {31'd0, done_cnt != d0}, 32'd1);
   endtask

   int h0, hw0, d0, p0, s0;

   initial begin
      rst_n = 1'b0; start = 1'b0; q_valid = 1'b0; q_data = '0;
      d_valid = 1'b0; d_data = '0; d_last = 1'b0; hit_ready = 1'b1;
      score_mode = 0; f_pv = 1'b0; f_pd = '0; f_rdy = 1'b0;
      done_cnt = 0; pad_cnt = 0; dhs_cnt = 0; sh_cnt = 0;
      #1;
      check("rst_outs", outs_vec, 32'd0);
      check("rst_outs_w", outs_w_vec, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // FIFO: fill, rejected push when full, push+pop when full, drain
      @(negedge clk) begin f_pv = 1'b1; f_pd = 16'd10; end
      @(negedge clk) f_pd = 16'd11;
      @(negedge clk) check("fifo_full", {14'd0, f_cnt, f_pos}, {14'd0, 2'd2, 16'd10});
      f_pd = 16'd99;
      @(negedge clk) check("fifo_reject", {14'd0, f_cnt, f_pos}, {14'd0, 2'd2, 16'd10});
      f_pd = 16'd12; f_rdy = 1'b1;
      @(negedge clk) check("fifo_pushpop", {14'd0, f_cnt, f_pos}, {14'd0, 2'd2, 16'd11});
      f_pv = 1'b0;
      @(negedge clk) check("fifo_pop1", {14'd0, f_cnt, f_pos}, {14'd0, 2'd1, 16'd12});
      @(negedge clk) check("fifo_empty", {30'd0, f_cnt}, 32'd0);
      f_rdy = 1'b0;

      // Single hit at position 2, three padded shifts
      score_mode = 0; hit_ready = 1'b1;
      h0 = hits.size(); d0 = done_cnt; p0 = pad_cnt;
      start_and_load("t1");
      stream(6);
      wait_done(d0);
      check("t1_hits", hits.size() - h0, 32'd1);
      if (hits.size() > h0) check("t1_pos", {16'd0, hits[h0]}, 32'd2);
      check("t1_pads", pad_cnt - p0, 32'd3);
      check("t1_done", done_cnt - d0, 32'd1);
      check("t1_idle", {31'd0, busy}, 32'd0);

      // Back-pressure: every shift hits, consumer stalled
      score_mode = 1; hit_ready = 1'b0;
      h0 = hits.size(); d0 = done_cnt;
      start_and_load("t2");
      s0 = dhs_cnt;
      fork
         stream(6);
         begin
            repeat (8) @(negedge clk);
            #2;
            check("t2_stall_dhs", dhs_cnt - s0, 32'd2);
            check("t2_stall", {29'd0, d_ready, hit_valid, busy}, 32'h3);
            check("t2_head", {16'd0, hit_pos}, 32'd0);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (3) @(negedge clk);
            #2;
            check("t2_hold", {15'd0, hit_valid, hit_pos}, {15'd0, 1'b1, 16'd0});
            check("t2_hold_dhs", dhs_cnt - s0, 32'd2);
            hit_ready = 1'b1;
         end
      join
      wait_done(d0);
      check("t2_hits", hits.size() - h0, 32'd9);
      for (int i = 0; i < 9; i++)
         if (h0 + i < hits.size()) check("t2_order", {16'd0, hits[h0 + i]}, i);
      check("t2_done", done_cnt - d0, 32'd1);

      // Reset while draining abandons the run
      score_mode = 1; hit_ready = 1'b1;
      d0 = done_cnt;
      start_and_load("t3");
      stream(2);
      for (int t = 0; t < 50 && !arr_pad; t++) @(negedge clk);
      check("t3_in_drain", {31'd0, arr_pad}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check("t3_rst_outs", outs_vec, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("t3_no_done", done_cnt - d0, 32'd0);

      // Clean rerun after abandoned run
      score_mode = 0; hit_ready = 1'b1;
      h0 = hits.size(); d0 = done_cnt; p0 = pad_cnt;
      start_and_load("t4");
      stream(6);
      wait_done(d0);
      check("t4_hits", hits.size() - h0, 32'd1);
      if (hits.size() > h0) check("t4_pos", {16'd0, hits[h0]}, 32'd2);
      check("t4_pads", pad_cnt - p0, 32'd3);
      check("t4_done", done_cnt - d0, 32'd1);

      // Position wrap on the 4-bit twin: 20 chars + 3 pads, all hits
      score_mode = 1; hit_ready = 1'b1;
      h0 = hits.size(); hw0 = hits_w.size(); d0 = done_cnt;
      start_and_load("t5");
      stream(20);
      wait_done(d0);
      check("t5_hits", hits.size() - h0, 32'd23);
      check("t5_hits_w", hits_w.size() - hw0, 32'd23);
      for (int i = 0; i < 23; i++)
         if (hw0 + i < hits_w.size()) check("t5_wrap", {28'd0, hits_w[hw0 + i]}, i % 16);
      if (h0 + 22 < hits.size()) check("t5_last", {16'd0, hits[h0 + 22]}, 32'd22);
`ifdef HIT_COUNT_EN
      check("t5_hit_count", {16'd0, hit_count}, hits.size() - h0);
      check("t5_hit_count_sat", {28'd0, hit_count_w}, 32'd15);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/align_scheduler.md
ALIGN_SCHEDULER -- requirements
Module: align_scheduler

Interface
REQ-001 SHALL have parameter QLEN, default 8, query length in PEs (2..64).
REQ-002 SHALL have parameter POS_W, default 16, database position width.
REQ-003 SHALL have parameter THRESH, default 2'b10, 2-bit hit score threshold.
REQ-004 SHALL have ports:
 clk  in  1  rising-edge clock, single clock domain
 rst_n  in  1  asynchronous active-low reset
 start  in  1  begin a run (IDLE only)
 q_valid/q_ready  in/out  1/1  query char handshake
 q_data  in  2  query nucleotide
 d_valid/d_ready  in/out  1/1  database char handshake
 d_data  in  2  database nucleotide
 d_last  in  1  final database char, qualified by d_valid&&d_ready
 arr_clear  out  1  clear all PE score registers
 arr_qload  out  1  write arr_qchar into PE arr_qidx
 arr_qidx  out  $clog2(QLEN)  PE index
 arr_qchar  out  2  query char to PE
 arr_shift  out  1  advance array one column
 arr_dchar  out  2  database char into array
 arr_pad  out  1  arr_dchar is padding
 arr_score  in  2  last-PE score, valid the cycle after arr_shift
 hit_valid/hit_ready  out/in  1/1  hit handshake
 hit_pos  out  POS_W  database index producing the hit
 busy  out  1  not IDLE
 done  out  1  one-cycle completion pulse

Function
REQ-005 SHALL implement FSM IDLE, CLEAR, LOAD, STREAM, DRAIN, FLUSH.
REQ-006 IDLE: start=1 -> CLEAR; start in any other state SHALL be ignored.
REQ-007 CLEAR: arr_clear=1 for exactly one cycle -> LOAD; qidx and pos counters SHALL reset to 0.
REQ-008 LOAD: q_ready=1; each q handshake SHALL assert arr_qload same cycle with arr_qidx=count, arr_qchar=q_data; after QLEN handshakes -> STREAM.
REQ-009 STREAM: d_ready = shift_ok; arr_shift = d_valid && shift_ok; arr_dchar=d_data, arr_pad=0.
REQ-010 shift_ok SHALL be 1 iff hit FIFO occupancy + in_flight < 2, in_flight = registered arr_shift of previous cycle.
REQ-011 Each shift SHALL capture pos into a 1-deep in-flight register then increment pos modulo 2^POS_W.
REQ-012 Cycle after any shift: arr_score >= THRESH (unsigned) SHALL push in-flight pos into 2-entry hit FIFO; else discard.
REQ-013 Handshake with d_last=1 -> DRAIN with drain counter = QLEN-1.
REQ-014 DRAIN: d_ready=0; arr_shift=shift_ok, arr_dchar=2'b00, arr_pad=1; counter decrements per shift; at 0 remaining -> FLUSH; hits and pos SHALL continue as in STREAM.
REQ-015 FLUSH: no shifts; when in_flight=0 and FIFO empty, done=1 for one cycle -> IDLE.
REQ-016 hit_valid SHALL equal FIFO non-empty, hit_pos = FIFO head; pop on hit_valid&&hit_ready; simultaneous push and pop SHALL both take effect.
REQ-017 hit_valid/hit_pos SHALL hold stable while hit_ready=0.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, clear counters, in-flight, FIFO; all outputs 0.
REQ-020 Reset mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-021 With HIT_COUNT_EN defined: extra output hit_count[POS_W-1:0], cleared in CLEAR, +1 per FIFO push, saturating at all-ones, held after done.
REQ-022 Without HIT_COUNT_EN: no hit_count port, no counter logic.

Structure
REQ-023 State encoding, THRESH default and nucleotide/pad codes SHALL live in shared package blastn_pkg.
REQ-024 Hit FIFO SHALL be sub-module hit_fifo2 (2-entry, POS_W wide, valid/ready).
REQ-025 Array datapath (gap adders, PEs) SHALL be outside this block.

Verification (QLEN=4)
REQ-026 Load A,C,G,T -> arr_qload four cycles, arr_qidx 0..3, then STREAM.
REQ-027 Stream 6 chars, last on 6th, hit_ready=1, arr_score=2 after shift at pos 2 only -> one hit, hit_pos=2; 3 padded shifts; done once.
REQ-028 arr_score=3 after every shift, hit_ready=0 -> d_ready drops after 2 pushes; no hit lost once hit_ready=1; positions in order.
REQ-029 Push and pop same cycle with FIFO full -> occupancy stays 2, order preserved.
REQ-030 rst_n low during DRAIN -> outputs 0 asynchronously, no done, next start runs cleanly.
REQ-031 POS_W=4, 20 chars -> hit_pos wraps 15->0; HIT_COUNT_EN build reports hit_count equal to hits delivered.
